// File: rtl/spm_port_arbiter_pkg.sv
// Shared constants for the scratchpad port arbiter: default widths and the
// round-robin requester encoding used for physical port 0.
package spm_port_arbiter_pkg;

  localparam int ADDR_WID_DEF = 13;
  localparam int DATA_WID_DEF = 32;
  localparam int CNT_WID_DEF  = 32;

  // Requester that wins the next contended cycle on physical port 0.
  typedef enum logic {
    RR_DMA = 1'b0,
    RR_KA  = 1'b1
  } rr_sel_e;

endpackage : spm_port_arbiter_pkg

// File: rtl/spm_port_arbiter_if.sv
// Bundle of the three scratchpad clients: DMA engine, kernel port A and
// kernel port B. The master side is the client, the slave side the arbiter.
interface spm_port_arbiter_if
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF
);

  // DMA fill/drain engine
  logic                dma_req;
  logic                dma_we;
  logic [ADDR_WID-1:0] dma_addr;
  logic [DATA_WID-1:0] dma_wdata;
  logic                dma_gnt;
  logic                dma_rvalid;
  logic [DATA_WID-1:0] dma_rdata;

  // Kernel port A (shares physical port 0 with the DMA)
  logic                ka_ce;
  logic                ka_we;
  logic [ADDR_WID-1:0] ka_addr;
  logic [DATA_WID-1:0] ka_d;
  logic                ka_gnt;
  logic [DATA_WID-1:0] ka_q;

  // Kernel port B (owns physical port 1)
  logic                kb_ce;
  logic                kb_we;
  logic [ADDR_WID-1:0] kb_addr;
  logic [DATA_WID-1:0] kb_d;
  logic [DATA_WID-1:0] kb_q;

  modport master (
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    output ka_ce, ka_we, ka_addr, ka_d,
    input  ka_gnt, ka_q,
    output kb_ce, kb_we, kb_addr, kb_d,
    input  kb_q
  );

  modport slave (
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    input  ka_ce, ka_we, ka_addr, ka_d,
    output ka_gnt, ka_q,
    input  kb_ce, kb_we, kb_addr, kb_d,
    output kb_q
  );

endinterface : spm_port_arbiter_if

// File: rtl/spm_ram_2p.sv
// Behavioural true dual-port read-first RAM. When both ports write the same
// word in one cycle, port 0 wins and the port-1 write is dropped.
module spm_ram_2p
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF
) (
  input  logic                clk,
  input  logic                en0,
  input  logic                we0,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic [DATA_WID-1:0] wdata0,
  output logic [DATA_WID-1:0] rdata0,
  input  logic                en1,
  input  logic                we1,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic [DATA_WID-1:0] wdata1,
  output logic [DATA_WID-1:0] rdata1
);

  localparam int DEPTH = 1 << ADDR_WID;

  logic [DATA_WID-1:0] mem [DEPTH];
  logic [DATA_WID-1:0] rdata0_q;
  logic [DATA_WID-1:0] rdata1_q;
  logic                wr0_en;
  logic                wr1_en;

  // Write enables; port 1 is suppressed when port 0 writes the same word.
  always_comb begin
    wr0_en = en0 & we0;
    wr1_en = en1 & we1 & ~(wr0_en & (addr0 == addr1));
  end

  // Array and read registers. Reads sample the array before this edge's
  // writes land, which gives read-first behaviour on both ports.
  // NOTE: the array and its read registers carry no reset: a reset would
  // turn the block RAM into flops, and consumers qualify rdata with their
  // own reset-cleared valid flags.
  always_ff @(posedge clk) begin
    if (en0) rdata0_q <= mem[addr0];
    if (en1) rdata1_q <= mem[addr1];
    if (wr0_en) mem[addr0] <= wdata0;
    if (wr1_en) mem[addr1] <= wdata1;
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule : spm_ram_2p

// File: rtl/spm_port_arbiter.sv
// Scratchpad port arbiter: DMA and kernel port A share physical port 0 under
// round-robin, kernel port B owns port 1. Read data returns one cycle after
// a granted read and holds otherwise; same-address dual writes are flagged.
module spm_port_arbiter
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int CNT_WID  = CNT_WID_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spm_port_arbiter_if.slave    bus,
  output logic                 collision,
  output logic [CNT_WID-1:0]   cont_cnt,
  input  logic                 stat_clr
);

  // Arbitration
  rr_sel_e             rr_ptr_q, rr_ptr_d;
  logic                contended;
  logic                dma_gnt;
  logic                ka_gnt;

  // Physical port 0 / port 1 controls
  logic                p0_en;
  logic                p0_we;
  logic [ADDR_WID-1:0] p0_addr;
  logic [DATA_WID-1:0] p0_wdata;
  logic [DATA_WID-1:0] p0_rdata;
  logic [DATA_WID-1:0] p1_rdata;

  // Read tracking and held read data
  logic                dma_rvalid_q, dma_rvalid_d;
  logic                ka_rd_q, ka_rd_d;
  logic                kb_rd_q, kb_rd_d;
  logic [DATA_WID-1:0] dma_hold_q, dma_hold_d;
  logic [DATA_WID-1:0] ka_hold_q, ka_hold_d;
  logic [DATA_WID-1:0] kb_hold_q, kb_hold_d;

  // Debug statistics
  logic                wr_collide;
  logic                collision_q, collision_d;
  logic [CNT_WID-1:0]  cont_cnt_q, cont_cnt_d;

  // Round-robin grant for port 0; on contention the pointer moves to the loser.
  // NOTE: every signal assigned here gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    contended = bus.dma_req & bus.ka_ce;
    dma_gnt   = bus.dma_req & (~bus.ka_ce | (rr_ptr_q == RR_DMA));
    ka_gnt    = bus.ka_ce & (~bus.dma_req | (rr_ptr_q == RR_KA));
    rr_ptr_d  = rr_ptr_q;
    if (contended) rr_ptr_d = (rr_ptr_q == RR_DMA) ? RR_KA : RR_DMA;
  end

  // Steer the granted requester onto physical port 0.
  always_comb begin
    p0_en    = dma_gnt | ka_gnt;
    p0_we    = dma_gnt ? bus.dma_we    : bus.ka_we;
    p0_addr  = dma_gnt ? bus.dma_addr  : bus.ka_addr;
    p0_wdata = dma_gnt ? bus.dma_wdata : bus.ka_d;
  end

  spm_ram_2p #(
    .ADDR_WID (ADDR_WID),
    .DATA_WID (DATA_WID)
  ) u_ram (
    .clk    (clk),
    .en0    (p0_en),
    .we0    (p0_we),
    .addr0  (p0_addr),
    .wdata0 (p0_wdata),
    .rdata0 (p0_rdata),
    .en1    (bus.kb_ce),
    .we1    (bus.kb_we),
    .addr1  (bus.kb_addr),
    .wdata1 (bus.kb_d),
    .rdata1 (p1_rdata)
  );

  // Remember which client issued a read this cycle; capture its data into the
  // hold register in the cycle it is presented so it persists afterwards.
  always_comb begin
    dma_rvalid_d = dma_gnt & ~bus.dma_we;
    ka_rd_d      = ka_gnt & ~bus.ka_we;
    kb_rd_d      = bus.kb_ce & ~bus.kb_we;
    dma_hold_d   = dma_rvalid_q ? p0_rdata : dma_hold_q;
    ka_hold_d    = ka_rd_q      ? p0_rdata : ka_hold_q;
    kb_hold_d    = kb_rd_q      ? p1_rdata : kb_hold_q;
  end

  // Sticky collision flag and saturating contention counter; clear wins.
  always_comb begin
    wr_collide  = p0_en & p0_we & bus.kb_ce & bus.kb_we & (p0_addr == bus.kb_addr);
    collision_d = collision_q | wr_collide;
    cont_cnt_d  = cont_cnt_q;
    if (contended && (cont_cnt_q != {CNT_WID{1'b1}})) cont_cnt_d = cont_cnt_q + CNT_WID'(1);
    if (stat_clr) begin
      collision_d = 1'b0;
      cont_cnt_d  = '0;
    end
  end

  // State registers; reset discards in-flight reads and re-favours the DMA.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= RR_DMA;
      dma_rvalid_q <= 1'b0;
      ka_rd_q      <= 1'b0;
      kb_rd_q      <= 1'b0;
      dma_hold_q   <= '0;
      ka_hold_q    <= '0;
      kb_hold_q    <= '0;
      collision_q  <= 1'b0;
      cont_cnt_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      dma_rvalid_q <= dma_rvalid_d;
      ka_rd_q      <= ka_rd_d;
      kb_rd_q      <= kb_rd_d;
      dma_hold_q   <= dma_hold_d;
      ka_hold_q    <= ka_hold_d;
      kb_hold_q    <= kb_hold_d;
      collision_q  <= collision_d;
      cont_cnt_q   <= cont_cnt_d;
    end
  end

  assign bus.dma_gnt    = dma_gnt;
  assign bus.ka_gnt     = ka_gnt;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rvalid_q ? p0_rdata : dma_hold_q;
  assign bus.ka_q       = ka_rd_q ? p0_rdata : ka_hold_q;
  assign bus.kb_q       = kb_rd_q ? p1_rdata : kb_hold_q;
  assign collision      = collision_q;
  assign cont_cnt       = cont_cnt_q;

endmodule : spm_port_arbiter

// File: tb/tb_spm_port_arbiter.sv
// Self-checking bench for spm_port_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural scratchpad model.
module tb_spm_port_arbiter;

  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stat_clr = 1'b0;
  logic          collision;
  logic [CW-1:0] cont_cnt;

  spm_port_arbiter_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus ();

  spm_port_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .CNT_WID(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .collision(collision),
    .cont_cnt (cont_cnt),
    .stat_clr (stat_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_dma_favoured;
  bit            m_rvalid;
  logic [DW-1:0] m_dma_rdata, m_ka_q, m_kb_q;
  bit            m_coll;
  int            m_cnt;
  bit            exp_dma_gnt, exp_ka_gnt;
  bit            obs_dma_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.ka_ce   = 1'b0; bus.ka_we  = 1'b0; bus.ka_addr  = '0; bus.ka_d      = '0;
    bus.kb_ce   = 1'b0; bus.kb_we  = 1'b0; bus.kb_addr  = '0; bus.kb_d      = '0;
    stat_clr    = 1'b0;
  endtask

  task automatic model_reset();
    m_dma_favoured = 1'b1;
    m_rvalid = 1'b0; m_dma_rdata = '0; m_ka_q = '0; m_kb_q = '0;
    m_coll = 1'b0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_dma_rvalid"}, 64'(bus.dma_rvalid), 64'(m_rvalid));
    if (m_rvalid) check({pfx, "_dma_rdata"}, 64'(bus.dma_rdata), 64'(m_dma_rdata));
    check({pfx, "_ka_q"}, 64'(bus.ka_q), 64'(m_ka_q));
    check({pfx, "_kb_q"}, 64'(bus.kb_q), 64'(m_kb_q));
    check({pfx, "_collision"}, 64'(collision), 64'(m_coll));
    check({pfx, "_cont_cnt"}, 64'(cont_cnt), 64'(m_cnt));
  endtask

  // One clock cycle: inputs already driven; check grants mid-cycle, advance
  // the model, then check registered outputs just after the edge.
  task automatic step();
    bit            both, p0_wr, kb_wr, collide;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    #2;
    both        = bus.dma_req && bus.ka_ce;
    exp_dma_gnt = bus.dma_req && (!bus.ka_ce || m_dma_favoured);
    exp_ka_gnt  = bus.ka_ce && (!bus.dma_req || !m_dma_favoured);
    obs_dma_gnt = bus.dma_gnt;
    check("dma_gnt", 64'(bus.dma_gnt), 64'(exp_dma_gnt));
    check("ka_gnt", 64'(bus.ka_gnt), 64'(exp_ka_gnt));

    m_rvalid = exp_dma_gnt && !bus.dma_we;
    if (m_rvalid) m_dma_rdata = m_mem[bus.dma_addr];
    if (exp_ka_gnt && !bus.ka_we) m_ka_q = m_mem[bus.ka_addr];
    if (bus.kb_ce && !bus.kb_we) m_kb_q = m_mem[bus.kb_addr];

    p0_wr   = (exp_dma_gnt && bus.dma_we) || (exp_ka_gnt && bus.ka_we);
    a0      = exp_dma_gnt ? bus.dma_addr : bus.ka_addr;
    d0      = exp_dma_gnt ? bus.dma_wdata : bus.ka_d;
    kb_wr   = bus.kb_ce && bus.kb_we;
    collide = p0_wr && kb_wr && (bus.kb_addr == a0);
    if (kb_wr && !collide) m_mem[bus.kb_addr] = bus.kb_d;
    if (p0_wr) m_mem[a0] = d0;

    if (stat_clr) begin
      m_coll = 1'b0;
      m_cnt  = 0;
    end else begin
      if (collide) m_coll = 1'b1;
      if (both && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    if (both) m_dma_favoured = !m_dma_favoured;

    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] old7;
    idle();
    model_reset();
    #12;
    check_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the whole scratchpad through the DMA so every word is known.
    for (int a = 0; a < DEPTH; a++) begin
      bus.dma_req = 1'b1; bus.dma_we = 1'b1;
      bus.dma_addr = AW'(a); bus.dma_wdata = $urandom;
      step();
    end

    // DMA write then read back of address 5.
    bus.dma_addr = AW'(5); bus.dma_wdata = 32'hDEADBEEF;
    step();
    check("p1_wr_gnt", 64'(obs_dma_gnt), 64'(1));
    bus.dma_we = 1'b0;
    step();
    check("p1_rd_gnt", 64'(obs_dma_gnt), 64'(1));
    check("p1_rvalid", 64'(bus.dma_rvalid), 64'(1));
    check("p1_rdata", 64'(bus.dma_rdata), 64'h0000_0000_DEAD_BEEF);
    idle();
    step();
    check("p1_rvalid_drop", 64'(bus.dma_rvalid), 64'(0));

    // Four contended read cycles: grants alternate starting with the DMA.
    bus.dma_req = 1'b1; bus.dma_addr = AW'(1);
    bus.ka_ce   = 1'b1; bus.ka_addr  = AW'(2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_alt", 64'(obs_dma_gnt), 64'((i % 2) == 0));
    end
    check("rr_cnt4", 64'(cont_cnt), 64'(4));

    // KA write while KB reads the same word: KB sees old data, then new.
    idle();
    old7 = m_mem[7];
    bus.ka_ce = 1'b1; bus.ka_we = 1'b1; bus.ka_addr = AW'(7); bus.ka_d = 32'h11;
    bus.kb_ce = 1'b1; bus.kb_addr = AW'(7);
    step();
    check("rfw_old", 64'(bus.kb_q), 64'(old7));
    bus.ka_ce = 1'b0;
    step();
    check("rfw_new", 64'(bus.kb_q), 64'h11);

    // Same-address dual write: port 0 wins and collision latches.
    idle();
    bus.ka_ce = 1'b1; bus.ka_we = 1'b1; bus.ka_addr = AW'(9); bus.ka_d = 32'hAA;
    bus.kb_ce = 1'b1; bus.kb_we = 1'b1; bus.kb_addr = AW'(9); bus.kb_d = 32'hBB;
    step();
    check("coll_set", 64'(collision), 64'(1));
    idle();
    bus.ka_ce = 1'b1; bus.ka_addr = AW'(9);
    step();
    check("coll_mem9", 64'(bus.ka_q), 64'hAA);
    check("coll_sticky", 64'(collision), 64'(1));
    // Clear coincides with a contended cycle: clear wins.
    bus.dma_req = 1'b1; bus.dma_addr = AW'(3);
    stat_clr = 1'b1;
    step();
    check("clr_coll", 64'(collision), 64'(0));
    check("clr_cnt", 64'(cont_cnt), 64'(0));

    // Saturation of the 4-bit counter.
    stat_clr = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", 64'(cont_cnt), 64'(CNT_MAX));

    // Randomized traffic; a losing requester holds its request stable.
    idle();
    step();
    for (int i = 0; i < 1500; i++) begin
      if (!(bus.dma_req && !exp_dma_gnt)) begin
        bus.dma_req   = ($urandom_range(0, 99) < 60);
        bus.dma_we    = 1'($urandom_range(0, 1));
        bus.dma_addr  = rand_addr();
        bus.dma_wdata = $urandom;
      end
      if (!(bus.ka_ce && !exp_ka_gnt)) begin
        bus.ka_ce   = ($urandom_range(0, 99) < 60);
        bus.ka_we   = 1'($urandom_range(0, 1));
        bus.ka_addr = rand_addr();
        bus.ka_d    = $urandom;
      end
      bus.kb_ce   = ($urandom_range(0, 99) < 60);
      bus.kb_we   = 1'($urandom_range(0, 1));
      bus.kb_addr = rand_addr();
      bus.kb_d    = $urandom;
      stat_clr    = ($urandom_range(0, 49) == 0);
      step();
    end

    // Asynchronous reset between edges with reads in flight.
    idle();
    bus.dma_req = 1'b1; bus.dma_addr = AW'(3);
    bus.ka_ce   = 1'b1; bus.ka_addr  = AW'(4);
    bus.kb_ce   = 1'b1; bus.kb_addr  = AW'(6);
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("arst");
    check("arst_rdata", 64'(bus.dma_rdata), 64'(0));
    idle();
    #3;
    reset_n = 1'b1;
    step();
    check("arst_no_rvalid", 64'(bus.dma_rvalid), 64'(0));
    bus.dma_req = 1'b1; bus.dma_addr = AW'(1);
    bus.ka_ce   = 1'b1; bus.ka_addr  = AW'(2);
    step();
    check("arst_rr_dma", 64'(obs_dma_gnt), 64'(1));
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spm_port_arbiter
